// File: rtl/apb_event_pkg.sv
// Shared types and address helper for the event-to-APB write scheduler.
package apb_event_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_1000;
  localparam int          DEF_ADDR_STRIDE = 4;

  // Register address of event idx; callers truncate to their address width.
  function automatic logic [63:0] calc_addr(input logic [63:0] base,
                                            input logic [31:0] stride,
                                            input logic [31:0] idx);
    return base + ({32'd0, stride} * {32'd0, idx});
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps modulo N.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  int j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/apb_event_sched.sv
// Event-to-APB write scheduler: counts event rises, arbitrates round-robin, issues one APB write per grant.
// Optional ACCESS watchdog compiled in with `define APB_EVENT_TIMEOUT_EN.
module apb_event_sched
  import apb_event_pkg::*;
#(
  parameter int                NUM_EV      = 3,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                CNT_W       = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
  parameter int                ADDR_STRIDE = DEF_ADDR_STRIDE,
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_EV-1:0] event_i,
  output logic              apb_psel_o,
  output logic              apb_penable_o,
  output logic [ADDR_W-1:0] apb_paddr_o,
  output logic              apb_pwrite_o,
  output logic [DATA_W-1:0] apb_pwdata_o,
  input  logic              apb_pready_i,
  output logic [NUM_EV-1:0] pending_o,
  output logic [NUM_EV-1:0] overflow_o,
  output logic              timeout_o,
  output state_t            dbg_state
);

  localparam int IW = (NUM_EV > 1) ? $clog2(NUM_EV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                         state_q;
  logic                           psel_q, penable_q;
  logic [ADDR_W-1:0]              paddr_q;
  logic [DATA_W-1:0]              pwdata_q;
  logic [IW-1:0]                  ptr_q;
  logic [NUM_EV-1:0]              prev_q, rise, ovf_q, ovf_d;
  logic [NUM_EV-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]               base;
  logic [NUM_EV-1:0]              arb_grant_unused;
  logic [IW-1:0]                  grant_idx;
  logic                           any, grant_fire;

  assign rise = event_i & ~prev_q;

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < NUM_EV; i++) pending_o[i] = |cnt_q[i];
  end

  rr_arbiter #(.N(NUM_EV)) u_arb (
    .req       (pending_o),
    .ptr       (ptr_q),
    .grant     (arb_grant_unused),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // A completing ACCESS re-arbitrates in the same cycle so writes run back-to-back.
  assign grant_fire = any && ((state_q == IDLE) || ((state_q == ACCESS) && apb_pready_i));

`ifdef APB_EVENT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]  timer_q;
  logic [IW-1:0]  idx_q;
  logic           tmo_q, timeout_fire;
  logic [CNT_W:0] sum;

  assign timeout_fire = (state_q == ACCESS) && !apb_pready_i && (timer_q == TW'(TIMEOUT_CYC - 1));
  assign timeout_o    = tmo_q;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYC);
  assign timeout_o  = 1'b0;
`endif

  // Counter update: clear on grant (or restore on abort), then apply this cycle's rise.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    base  = '0;
`ifdef APB_EVENT_TIMEOUT_EN
    sum   = '0;
`endif
    for (int i = 0; i < NUM_EV; i++) begin
      base = cnt_q[i];
      if (grant_fire && (grant_idx == IW'(i))) base = '0;
`ifdef APB_EVENT_TIMEOUT_EN
      if (timeout_fire && (idx_q == IW'(i))) begin
        sum  = {1'b0, cnt_q[i]} + {1'b0, pwdata_q[CNT_W-1:0]};
        base = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
      end
`endif
      cnt_d[i] = base;
      if (rise[i]) begin
        if (base == CNT_MAX) ovf_d[i] = 1'b1;
        else                 cnt_d[i] = base + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= '0;
    end else begin
      prev_q <= event_i;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      ptr_q     <= '0;
`ifdef APB_EVENT_TIMEOUT_EN
      timer_q   <= '0;
      idx_q     <= '0;
      tmo_q     <= 1'b0;
`endif
    end else if (grant_fire) begin
      state_q   <= SETUP;
      psel_q    <= 1'b1;
      penable_q <= 1'b0;
      paddr_q   <= ADDR_W'(calc_addr(64'(BASE_ADDR), 32'(ADDR_STRIDE), 32'(grant_idx)));
      pwdata_q  <= DATA_W'(cnt_q[grant_idx]);
      ptr_q     <= (grant_idx == IW'(NUM_EV - 1)) ? '0 : grant_idx + IW'(1);
`ifdef APB_EVENT_TIMEOUT_EN
      idx_q     <= grant_idx;
`endif
    end else begin
      case (state_q)
        IDLE: begin
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
`ifdef APB_EVENT_TIMEOUT_EN
          timer_q   <= '0;
`endif
        end
        ACCESS: begin
          if (apb_pready_i) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
          end
`ifdef APB_EVENT_TIMEOUT_EN
          else if (timeout_fire) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            tmo_q     <= 1'b1;
          end else begin
            timer_q   <= timer_q + TW'(1);
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign apb_psel_o    = psel_q;
  assign apb_penable_o = penable_q;
  assign apb_paddr_o   = paddr_q;
  assign apb_pwrite_o  = psel_q;
  assign apb_pwdata_o  = pwdata_q;
  assign overflow_o    = ovf_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/apb_event_sched.md
Name: apb_event_sched

Overview:
- Event-to-APB write scheduler.
- Edge-detects NUM_EV event inputs and counts each event's occurrences while it waits for service.
- Arbitrates pending events round-robin.
- Sequences one APB write per grant (SETUP/ACCESS with wait-states) to a per-event register address.
- Sits between the event sources and the APB interconnect, replacing fixed-priority event handling.

Parameters:
- NUM_EV, 3, number of event inputs (index 0 = event a).
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB write-data width.
- CNT_W, 8, per-event occurrence counter width (CNT_W <= DATA_W).
- BASE_ADDR, 32'h0000_1000, address of event 0's register.
- ADDR_STRIDE, 4, address step between event registers.
- TIMEOUT_CYC, 16, ACCESS-phase watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- event_i  in  NUM_EV  level event inputs; a 0->1 rise is one occurrence.
- apb_psel_o  out  1  APB select.
- apb_penable_o  out  1  APB enable.
- apb_paddr_o  out  ADDR_W  BASE_ADDR + idx*ADDR_STRIDE.
- apb_pwrite_o  out  1  1 whenever psel=1, else 0.
- apb_pwdata_o  out  DATA_W  zero-extended occurrence count of the granted event.
- apb_pready_i  in  1  completer ready.
- pending_o  out  NUM_EV  bit i = counter i nonzero.
- overflow_o  out  NUM_EV  sticky: a rise arrived while counter i was saturated.
- timeout_o  out  1  sticky watchdog flag; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset (synchronous, active-high): all outputs 0; state IDLE; counters, prev-event register, sticky flags and round-robin pointer cleared; pointer gives index 0 highest priority.
- Edge detect: rise_i = event_i & ~prev_i, with prev registered every cycle.
- A rise increments counter i, saturating at 2^CNT_W-1.
- A rise on a saturated counter sets overflow_o[i]; it stays set until reset.
- FSM states are IDLE, SETUP, ACCESS.
- IDLE: if any pending_o bit is 1, the round-robin arbiter grants one index, starting search at last_grant+1 modulo NUM_EV.
  - On the grant edge: capture idx, capture count into pwdata, clear counter idx, advance pointer; go to SETUP.
  - A rise on idx in that same cycle leaves the counter at 1, not 0.
- Latency: a rise sampled at edge k gives pending=1 after edge k; psel=1 after edge k+1.
- SETUP (1 cycle): psel=1, penable=0, pwrite=1; paddr/pwdata valid and held stable through ACCESS; go to ACCESS.
- ACCESS: psel=1, penable=1; hold all outputs while apb_pready_i=0.
  - On pready=1, the transfer completes that edge.
  - If any event is pending (re-arbitrated that cycle), go directly to SETUP (back-to-back, no idle cycle); else go to IDLE with psel=penable=0.
- Outside a transfer, paddr/pwdata hold their last values; pwrite=0.
- Simultaneous rises on several events are all counted; service order is set by the round-robin pointer.
- Reset asserted mid-transfer: psel/penable drop at that edge; the transfer is abandoned, not retried.

Optional Feature:
- Macro APB_EVENT_TIMEOUT_EN.
- Defined: a cycle counter runs in ACCESS. If pready is still 0 after TIMEOUT_CYC ACCESS cycles:
  - psel/penable drop and the FSM returns to IDLE;
  - timeout_o is set (sticky);
  - the captured count is added back to counter idx (saturating), so the event is retried later.
- Undefined: no watchdog; ACCESS waits indefinitely; timeout_o is constant 0.

Decomposition:
- Package apb_event_pkg holds:
  - state enum (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2);
  - default BASE_ADDR and ADDR_STRIDE constants;
  - an address-calculation function.
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr; outputs grant one-hot, grant_idx, any. Purely combinational; the pointer register stays in apb_event_sched.

Test Plan:
- Single rise on event_i[0], pready=1 throughout -> one transfer: psel high 2 cycles, paddr=0x1000, pwdata=1, pwrite=1; then IDLE with psel=0.
- Hold pready=0 for 5 ACCESS cycles on an event-0 transfer while event_i[1] pulses 3 times -> next transfer paddr=0x1004, pwdata=3; outputs stable during the wait.
- Events 0,1,2 rise in the same cycle, pready=1 -> back-to-back writes to 0x1000, 0x1004, 0x1008 with no IDLE cycle between; pending_o steps 111->110->100->000.
- Round-robin: last grant=2, events 0 and 1 both pending -> 0 served, then 1; after a grant of 1 with 1 and 2 pending -> 2 before 1.
- CNT_W=2, event 0 rises 5 times while blocked -> pwdata=3 and overflow_o[0]=1, still set after the transfer.
- Reset during ACCESS -> after that edge all outputs 0 and pending_o=0. With APB_EVENT_TIMEOUT_EN and pready stuck 0 -> abort after 16 ACCESS cycles, timeout_o=1, event re-requested with its original count.
